prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter.sv | 96 +++++++++
 tb/tb_prog_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Parameterised up/down counter with bounded range, programmable step, and
// WRAP / SATURATE / ONESHOT boundary behaviour driven by an IDLE/RUN/DONE FSM.
module prog_counter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COUNT_FROM = 0,
    parameter int unsigned COUNT_TO   = 255,
    parameter int unsigned STEP       = 1,
    parameter string       MODE       = "WRAP"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam bit IS_SAT = (MODE == "SATURATE");
    localparam bit IS_ONE = (MODE == "ONESHOT");
    localparam bit IS_WRAP = !IS_SAT && !IS_ONE;

    // Boundary arithmetic is one bit wider than the count so it cannot overflow.
    localparam logic [DATA_WIDTH:0]   FROM_X = (DATA_WIDTH+1)'(COUNT_FROM);
    localparam logic [DATA_WIDTH:0]   TO_X   = (DATA_WIDTH+1)'(COUNT_TO);
    localparam logic [DATA_WIDTH:0]   STEP_X = (DATA_WIDTH+1)'(STEP);
    localparam logic [DATA_WIDTH-1:0] FROM_N = DATA_WIDTH'(COUNT_FROM);
    localparam logic [DATA_WIDTH-1:0] TO_N   = DATA_WIDTH'(COUNT_TO);
    localparam logic [DATA_WIDTH-1:0] STEP_N = DATA_WIDTH'(STEP);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  tc_q, tc_d;

    logic [DATA_WIDTH:0]   up_sum;
    logic [DATA_WIDTH-1:0] dn_diff;
    logic                  term;
    logic [DATA_WIDTH-1:0] bound;

    always_comb begin
        up_sum  = {1'b0, out_q} + STEP_X;
        dn_diff = out_q - STEP_N;
        term    = dir ? ({1'b0, out_q} < (FROM_X + STEP_X)) : (up_sum > TO_X);
        // WRAP re-enters from the opposite end; the other modes clamp to the near end.
        if (IS_WRAP) bound = dir ? TO_N : FROM_N;
        else         bound = dir ? FROM_N : TO_N;

        state_d = state_q;
        out_d   = out_q;
        tc_d    = 1'b0;
        if (clr) begin
            out_d = FROM_N;
        end else if (load) begin
            out_d = load_val;
        end else if (start && state_q != S_RUN) begin
            state_d = S_RUN;
            if (state_q == S_DONE) out_d = FROM_N;
        end else if (state_q == S_RUN && en) begin
            if (term) begin
                out_d = bound;
                // A saturated counter already parked on its bound does not pulse again.
                tc_d  = !(IS_SAT && out_q == bound);
                if (IS_ONE) state_d = S_DONE;
            end else begin
                out_d = dir ? dn_diff : up_sum[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= FROM_N;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            tc_q    <= tc_d;
        end
    end

    assign out  = out_q;
    assign tc   = tc_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Drives one WRAP, one SATURATE and one ONESHOT counter from shared inputs and
// compares each against an arithmetic reference model plus directed sequences.
module tb_prog_counter;

    localparam int FROM = 2;
    localparam int TO   = 10;
    localparam int STEP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] out_w [3];
    logic       tc_w [3], busy_w [3], done_w [3];

    prog_counter #(.DATA_WIDTH(8), .COUNT_FROM(FROM), .COUNT_TO(TO), .STEP(STEP), .MODE("WRAP")) u_wrap (
        .clk(clk), .rst(rst), .start(start), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .out(out_w[0]), .tc(tc_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    prog_counter #(.DATA_WIDTH(8), .COUNT_FROM(FROM), .COUNT_TO(TO), .STEP(STEP), .MODE("SATURATE")) u_sat (
        .clk(clk), .rst(rst), .start(start), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .out(out_w[1]), .tc(tc_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    prog_counter #(.DATA_WIDTH(8), .COUNT_FROM(FROM), .COUNT_TO(TO), .STEP(STEP), .MODE("ONESHOT")) u_one (
        .clk(clk), .rst(rst), .start(start), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .out(out_w[2]), .tc(tc_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    // Reference model: index 0 = WRAP, 1 = SATURATE, 2 = ONESHOT; state 0 idle, 1 run, 2 done.
    int m_out [3];
    int m_st  [3];
    bit m_tc  [3];
    int vectors = 0;
    int miscompares = 0;

    task automatic model_edge();
        for (int m = 0; m < 3; m++) begin
            int nxt, bnd;
            bit term;
            if (rst) begin
                m_out[m] = FROM; m_tc[m] = 0; m_st[m] = 0;
            end else if (clr) begin
                m_out[m] = FROM; m_tc[m] = 0;
            end else if (load) begin
                m_out[m] = int'(load_val); m_tc[m] = 0;
            end else if (start && m_st[m] != 1) begin
                if (m_st[m] == 2) m_out[m] = FROM;
                m_st[m] = 1; m_tc[m] = 0;
            end else if (m_st[m] == 1 && en) begin
                nxt  = dir ? m_out[m] - STEP : m_out[m] + STEP;
                term = dir ? (nxt < FROM) : (nxt > TO);
                if (!term) begin
                    m_out[m] = nxt; m_tc[m] = 0;
                end else begin
                    bnd = ((m == 0) != dir) ? FROM : TO;
                    m_tc[m]  = !(m == 1 && m_out[m] == bnd);
                    m_out[m] = bnd;
                    if (m == 2) m_st[m] = 2;
                end
            end else begin
                m_tc[m] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; en = 1'b1; load = 1'b1; clr = 1'b0; load_val = 8'd77;
        tick(); tick();
        for (int m = 0; m < 3; m++) begin
            vectors++;
            if (out_w[m] !== 8'(FROM) || tc_w[m] !== 1'b0 || busy_w[m] !== 1'b0 || done_w[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset m%0d: got out=%0d tc=%b busy=%b done=%b want out=%0d tc=0 busy=0 done=0",
                         m, out_w[m], tc_w[m], busy_w[m], done_w[m], FROM);
            end
        end
        rst = 1'b0; start = 1'b0; en = 1'b0; load = 1'b0;
    endtask

    task automatic test_count_up();
        int exp_out [3][5] = '{'{5, 8, 2, 5, 8}, '{5, 8, 10, 10, 10}, '{5, 8, 10, 10, 10}};
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int m = 0; m < 3; m++) begin
            vectors++;
            if (out_w[m] !== 8'(FROM) || busy_w[m] !== 1'b1) begin
                miscompares++;
                $display("FAIL start_arm m%0d: got out=%0d busy=%b want out=%0d busy=1", m, out_w[m], busy_w[m], FROM);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (out_w[m] !== 8'(exp_out[m][i]) || tc_w[m] !== (i == 2)) begin
                    miscompares++;
                    $display("FAIL count_up m%0d step%0d: got out=%0d tc=%b want out=%0d tc=%b",
                             m, i, out_w[m], tc_w[m], exp_out[m][i], (i == 2));
                end
            end
            vectors++;
            if (done_w[2] !== (i >= 2) || busy_w[2] !== (i < 2)) begin
                miscompares++;
                $display("FAIL oneshot_flags step%0d: got done=%b busy=%b want done=%b busy=%b",
                         i, done_w[2], busy_w[2], (i >= 2), (i < 2));
            end
        end
        start = 1'b1; tick(); start = 1'b0; en = 1'b0;
        vectors++;
        if (out_w[2] !== 8'(FROM) || busy_w[2] !== 1'b1 || done_w[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_rearm: got out=%0d busy=%b done=%b want out=%0d busy=1 done=0",
                     out_w[2], busy_w[2], done_w[2], FROM);
        end
        for (int m = 0; m < 2; m++) begin
            vectors++;
            if (out_w[m] !== 8'(m_out[m]) || tc_w[m] !== m_tc[m]) begin
                miscompares++;
                $display("FAIL start_in_run m%0d: got out=%0d tc=%b want out=%0d tc=%b",
                         m, out_w[m], tc_w[m], m_out[m], m_tc[m]);
            end
        end
    endtask

    task automatic test_load_down();
        int exp_w [4] = '{7, 4, 10, 2};
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        load = 1'b1; load_val = 8'd10; tick(); load = 1'b0;
        vectors++;
        if (out_w[0] !== 8'd10 || tc_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL load: got out=%0d tc=%b want out=10 tc=0", out_w[0], tc_w[0]);
        end
        dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dir = 1'b0;   // reversal applies to the very next step
            tick();
            vectors++;
            if (out_w[0] !== 8'(exp_w[i]) || tc_w[0] !== (i >= 2)) begin
                miscompares++;
                $display("FAIL wrap_down step%0d: got out=%0d tc=%b want out=%0d tc=%b",
                         i, out_w[0], tc_w[0], exp_w[i], (i >= 2));
            end
            for (int m = 1; m < 3; m++) begin
                vectors++;
                if (out_w[m] !== 8'(m_out[m]) || tc_w[m] !== m_tc[m] || done_w[m] !== (m_st[m] == 2)) begin
                    miscompares++;
                    $display("FAIL down m%0d step%0d: got out=%0d tc=%b done=%b want out=%0d tc=%b done=%b",
                             m, i, out_w[m], tc_w[m], done_w[m], m_out[m], m_tc[m], (m_st[m] == 2));
                end
            end
        end
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; tick();
        clr = 1'b1; load = 1'b1; load_val = 8'd9; tick();
        for (int m = 0; m < 3; m++) begin
            vectors++;
            if (out_w[m] !== 8'(FROM) || tc_w[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL clr_wins m%0d: got out=%0d tc=%b want out=%0d tc=0", m, out_w[m], tc_w[m], FROM);
            end
        end
        clr = 1'b0; tick();
        for (int m = 0; m < 3; m++) begin
            vectors++;
            if (out_w[m] !== 8'd9 || tc_w[m] !== 1'b0 || busy_w[m] !== 1'b1) begin
                miscompares++;
                $display("FAIL load_over_en m%0d: got out=%0d tc=%b busy=%b want out=9 tc=0 busy=1",
                         m, out_w[m], tc_w[m], busy_w[m]);
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int m = 0; m < 3; m++) begin
            vectors++;
            if (out_w[m] !== 8'(FROM) || busy_w[m] !== 1'b0 || tc_w[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid m%0d: got out=%0d busy=%b tc=%b want out=%0d busy=0 tc=0",
                         m, out_w[m], busy_w[m], tc_w[m], FROM);
            end
        end
        tick();
        start = 1'b1; tick(); start = 1'b0; tick();
        vectors++;
        if (out_w[0] !== 8'(FROM + STEP) || tc_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL resume: got out=%0d tc=%b want out=%0d tc=0", out_w[0], tc_w[0], FROM + STEP);
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(59) == 0);
            clr      = ($urandom_range(24) == 0);
            load     = ($urandom_range(14) == 0);
            start    = ($urandom_range(7) == 0);
            en       = ($urandom_range(3) != 0);
            dir      = ($urandom_range(5) == 0) ? ~dir : dir;
            load_val = 8'($urandom_range(255));
            tick();
            for (int m = 0; m < 3; m++) begin
                vectors++;
                if (out_w[m] !== 8'(m_out[m]) || tc_w[m] !== m_tc[m] ||
                    busy_w[m] !== (m_st[m] == 1) || done_w[m] !== (m_st[m] == 2)) begin
                    miscompares++;
                    $display("FAIL random m%0d cyc%0d: got out=%0d tc=%b busy=%b done=%b want out=%0d tc=%b busy=%b done=%b",
                             m, i, out_w[m], tc_w[m], busy_w[m], done_w[m],
                             m_out[m], m_tc[m], (m_st[m] == 1), (m_st[m] == 2));
                end
            end
        end
        rst = 1'b0; clr = 1'b0; load = 1'b0; start = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_down();
        test_priority();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
